// File: rtl/sim_irq_gen.sv
// Multi-channel test interrupt generator for the simulation top.
// Each channel has its own period, one-shot/periodic mode, pulse/level output and a sticky overrun flag.

module sim_irq_gen_ch #(
    parameter int               CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 'h60
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             use_default_i,
    input  logic             oneshot_i,
    input  logic             level_i,
    input  logic             ack_i,
    input  logic             clr_ovr_i,
    output logic             irq_d_o,
    output logic             irq_o,
    output logic             overrun_o
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             irq_q, irq_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] eff_per;
    logic             expire;
    logic             ovr_set;

    // A zero slice means "no period" unless the default is allowed to stand in.
    assign eff_per = (period_i != '0) ? period_i
                   : (use_default_i ? DEFAULT_PERIOD : '0);
    assign expire  = (state_q == COUNT) && (cnt_q == per_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        irq_d   = irq_q;
        ovr_set = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (eff_per != '0) begin
                        state_d = COUNT;
                        per_d   = eff_per;
                    end
                end
                COUNT: begin
                    if (expire) begin
                        cnt_d = '0;
                        // Keep the old period if the slice went to zero mid-run.
                        if (eff_per != '0) per_d = eff_per;
                        if (oneshot_i) state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE:    cnt_d   = '0;
                default: state_d = IDLE;
            endcase
            if (level_i) begin
                // An ack in the expiry cycle retires the old event; the new one stays raised.
                irq_d   = expire | (irq_q & ~ack_i);
                ovr_set = expire & irq_q & ~ack_i;
            end else begin
                irq_d   = expire;
            end
        end
    end

    assign ovr_d = ovr_set | (ovr_q & ~clr_ovr_i);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            irq_q   <= irq_d;
            ovr_q   <= ovr_d;
        end
    end

    assign irq_d_o   = irq_d;
    assign irq_o     = irq_q;
    assign overrun_o = ovr_q;
endmodule

module sim_irq_gen #(
    parameter int               NUM_CH         = 4,
    parameter int               CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 'h60
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CH-1:0]       enable_i,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    input  logic                    use_default_i,
    input  logic [NUM_CH-1:0]       oneshot_i,
    input  logic [NUM_CH-1:0]       level_i,
    input  logic [NUM_CH-1:0]       irq_ack_i,
    input  logic [NUM_CH-1:0]       clear_overrun_i,
    output logic [NUM_CH-1:0]       irq_o,
    output logic [NUM_CH-1:0]       overrun_o,
    output logic                    irq_any_o
);
    logic [NUM_CH-1:0] irq_d;
    logic              irq_any_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        sim_irq_gen_ch #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .enable_i      (enable_i[n]),
            .period_i      (period_i[n*CNT_W +: CNT_W]),
            .use_default_i (use_default_i),
            .oneshot_i     (oneshot_i[n]),
            .level_i       (level_i[n]),
            .ack_i         (irq_ack_i[n]),
            .clr_ovr_i     (clear_overrun_i[n]),
            .irq_d_o       (irq_d[n]),
            .irq_o         (irq_o[n]),
            .overrun_o     (overrun_o[n])
        );
    end

    // Built from next-state so it lines up cycle-for-cycle with irq_o.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) irq_any_q <= 1'b0;
        else          irq_any_q <= |irq_d;
    end

    assign irq_any_o = irq_any_q;
endmodule

// File: tb/tb_sim_irq_gen.sv
// Directed bench for sim_irq_gen: periodic/one-shot, pulse/level, overrun, default period, async reset.

module tb_sim_irq_gen;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*CNT_W-1:0] period;
    logic                    use_default;
    logic [NUM_CH-1:0]       oneshot;
    logic [NUM_CH-1:0]       level;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       clr_ovr;
    logic [NUM_CH-1:0]       irq;
    logic [NUM_CH-1:0]       overrun;
    logic                    irq_any;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sim_irq_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(32'h60)) dut (
        .clk_i           (clk),
        .reset_i         (rst_n),
        .enable_i        (enable),
        .period_i        (period),
        .use_default_i   (use_default),
        .oneshot_i       (oneshot),
        .level_i         (level),
        .irq_ack_i       (ack),
        .clear_overrun_i (clr_ovr),
        .irq_o           (irq),
        .overrun_o       (overrun),
        .irq_any_o       (irq_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_per(input int ch, input logic [31:0] v);
        period[ch*CNT_W +: CNT_W] = v;
    endtask

    task automatic do_reset();
        enable = '0; period = '0; use_default = 1'b0; oneshot = '0;
        level = '0; ack = '0; clr_ovr = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        enable = '0; period = '0; use_default = 1'b0; oneshot = '0;
        level = '0; ack = '0; clr_ovr = '0;
        @(negedge clk);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_any", 32'(irq_any), 32'h0);

        // ch0: period 0x60, periodic pulse; enable sampled at edge 0
        do_reset();
        set_per(0, 32'h60);
        enable[0] = 1'b1;
        for (int e = 0; e <= 300; e++) begin
            step();
            chk($sformatf("ch0_irq_e%0d", e), 32'(irq[0]), 32'(e == 97 || e == 194 || e == 291));
            chk($sformatf("ch0_any_e%0d", e), 32'(irq_any), 32'(e == 97 || e == 194 || e == 291));
        end
        chk("ch0_ovr", 32'(overrun), 32'h0);

        // ch1: period 5, one-shot level, ack in cycle 40
        do_reset();
        set_per(1, 32'd5);
        oneshot[1] = 1'b1; level[1] = 1'b1; enable[1] = 1'b1;
        for (int e = 0; e <= 60; e++) begin
            step();
            ack[1] = (e == 40);
            chk($sformatf("ch1_irq_e%0d", e), 32'(irq[1]), 32'(e >= 6 && e <= 40));
        end
        chk("ch1_ovr", 32'(overrun), 32'h0);

        // ch2: period 3, periodic level never acked; clear at edges 11 and 12 (12 collides with a set)
        do_reset();
        set_per(2, 32'd3);
        level[2] = 1'b1; enable[2] = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            step();
            chk($sformatf("ch2_irq_e%0d", e), 32'(irq[2]), 32'(e >= 4));
            chk($sformatf("ch2_ovr_e%0d", e), 32'(overrun[2]), 32'(e >= 8 && e != 11));
            clr_ovr[2] = (e == 10 || e == 11);
        end

        // ch3: period 3, level, ack exactly in each expiry cycle
        do_reset();
        set_per(3, 32'd3);
        level[3] = 1'b1; enable[3] = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            step();
            chk($sformatf("ch3_irq_e%0d", e), 32'(irq[3]), 32'(e >= 4));
            chk($sformatf("ch3_ovr_e%0d", e), 32'(overrun[3]), 32'h0);
            ack[3] = (e >= 3) && ((e + 1) % 4 == 0);
        end

        // zero period without default stays idle; then default 0x60 kicks in
        do_reset();
        enable[0] = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 500; e++) begin
            step();
            seen = seen | irq[0];
        end
        chk("zero_per_idle", 32'(seen), 32'h0);
        use_default = 1'b1;
        for (int e = 0; e <= 97; e++) begin
            step();
            if (e == 96) chk("dflt_e96", 32'(irq[0]), 32'h0);
            if (e == 97) chk("dflt_e97", 32'(irq[0]), 32'h1);
        end

        // simultaneous expiries on two channels
        do_reset();
        set_per(0, 32'd2); set_per(1, 32'd2);
        enable[1:0] = 2'b11;
        for (int e = 0; e <= 4; e++) begin
            step();
            if (e >= 2) chk($sformatf("sim_irq_e%0d", e), 32'(irq), (e == 3) ? 32'h3 : 32'h0);
            if (e == 3) chk("sim_any", 32'(irq_any), 32'h1);
        end

        // async reset mid-count with irq and overrun set
        do_reset();
        set_per(2, 32'd3);
        level[2] = 1'b1; enable[2] = 1'b1;
        for (int e = 0; e <= 9; e++) step();
        chk("pre_rst_irq", 32'(irq[2]), 32'h1);
        chk("pre_rst_ovr", 32'(overrun[2]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_ovr", 32'(overrun), 32'h0);
        chk("arst_any", 32'(irq_any), 32'h0);
        enable = '0;
        #1 rst_n = 1'b1;
        step();
        enable[2] = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            chk($sformatf("rerun_irq_e%0d", e), 32'(irq[2]), 32'(e >= 4));
            chk($sformatf("rerun_ovr_e%0d", e), 32'(overrun[2]), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sim_irq_gen.md
Name: sim_irq_gen

Overview:
- Parametrised multi-channel test interrupt generator for the Verilator simulation top; replaces the fixed single-channel 0x60-cycle IRQ counter.
- Each channel has its own period, periodic/one-shot mode, pulse/level output mode and ack handshake; it drives the SoC test IRQ inputs to exercise the interrupt controller and trap handlers.
- Sticky per-channel overrun flags record expiries that were lost while a level IRQ waited for ack.

Parameters:
- NUM_CH, 4, number of independent IRQ channels (1..16)
- CNT_W, 32, counter and period width in bits
- DEFAULT_PERIOD, 32'h60, period used by a channel whose period_i slice is zero while use_default_i is set

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  NUM_CH  per-channel enable
- period_i  in  NUM_CH*CNT_W  packed periods; channel n is bits [n*CNT_W +: CNT_W]
- use_default_i  in  1  substitute DEFAULT_PERIOD for any zero period slice
- oneshot_i  in  NUM_CH  1 = fire once then stop; 0 = periodic
- level_i  in  NUM_CH  1 = level IRQ held until ack; 0 = single-cycle pulse
- irq_ack_i  in  NUM_CH  per-channel acknowledge, level mode only
- clear_overrun_i  in  NUM_CH  clears the matching overrun bit
- irq_o  out  NUM_CH  interrupt outputs
- overrun_o  out  NUM_CH  sticky overrun flags
- irq_any_o  out  1  OR of irq_o, registered with irq_o

Behaviour:
- Reset (reset_i low, asynchronous): all channels go to IDLE; counters = 0; irq_o = 0; overrun_o = 0; irq_any_o = 0.
- Effective period P: the channel's period_i slice. If the slice is 0, P = DEFAULT_PERIOD when use_default_i = 1; otherwise the channel never leaves IDLE.
- P is latched on the IDLE->COUNT transition and on every reload. A change to period_i mid-count takes effect at the next reload.
- Per-channel states: IDLE, COUNT, DONE.
- IDLE: counter = 0. Go to COUNT on the cycle after enable_i = 1 and P != 0.
- COUNT: counter increments by 1 each cycle. In the cycle where counter == P:
  - counter reloads to 0;
  - irq_o is set on the next edge;
  - the channel goes to DONE if oneshot_i = 1, else stays in COUNT.
- Latency: with enable_i rising at edge 0, irq_o first goes high after edge P+1. The period between periodic expiries is P+1 cycles (P = 0x60 gives 97 cycles).
- Pulse mode (level_i = 0): irq_o is high for exactly one cycle per expiry. irq_ack_i is ignored. Overrun is never set.
- Level mode (level_i = 1): irq_o stays high until a cycle with irq_ack_i = 1, and clears on the next edge.
  - A new expiry while irq_o is already high and no ack is present sets overrun_o; irq_o stays high.
  - A new expiry in the same cycle as an ack: irq_o stays high and overrun is not set (the ack consumes the old event, the new one is raised).
  - An ack while irq_o = 0 is a no-op.
- DONE: no counting. irq_o in level mode still waits for ack. Return to IDLE when enable_i = 0.
- enable_i deasserted in any state: next edge goes to IDLE, counter = 0, irq_o = 0. overrun_o is preserved.
- clear_overrun_i: clears the bit on the next edge. If it coincides with a new overrun event, set wins.
- Counter arithmetic: CNT_W wide, unsigned. The counter never exceeds P, so no wrap occurs. P = 2^CNT_W-1 is legal.
- Channels are fully independent; simultaneous expiries on several channels all fire in the same cycle.

Test Plan:
- Reset, then ch0 enable=1, period=0x60, periodic, pulse -> irq_o[0] high only at cycles 97, 194, 291 after enable; single-cycle pulses; overrun_o = 0.
- ch1 period=5, oneshot, level, no ack for 40 cycles -> irq_o[1] rises at cycle 6 and stays high; no further expiry; ack at cycle 40 -> low at cycle 41; channel remains in DONE.
- ch2 period=3, periodic, level, never acked -> irq_o[2] high from cycle 4; overrun_o[2] set at cycle 8; clear_overrun at cycle 10 -> overrun low at 11, set again at 12.
- ch3 period=3, periodic, level, ack asserted exactly in each expiry cycle -> irq_o[3] stays high continuously; overrun_o[3] stays 0.
- period slice=0 with use_default_i=0 -> no IRQ over 500 cycles; then use_default_i=1 -> IRQ 97 cycles after the enable-latch cycle.
- reset_i pulled low asynchronously mid-count with irq_o and overrun_o set -> all outputs 0 immediately without a clock edge; after release and re-enable, counting restarts from 0.
